ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_MAX, default 4: the maximum number of consecutive cycles the DMA may be denied while it is ready to access.
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  the single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  the CPU accesses RAM this cycle.
- cpu_address  in  16  CPU word address; only bits [11:0] are used.
- cpu_in  in  16  CPU write data.
- cpu_load  in  1  CPU write enable.
- cpu_out  out  16  read data, equal to ram_out.
- cpu_wait  out  1  CPU access not granted this cycle; the CPU holds its request.
- dma_start  in  1  one-cycle command pulse.
- dma_base  in  12  first word address of the transfer.
- dma_len  in  12  number of words to transfer.
- dma_write  in  1  1 = stream into RAM, 0 = stream out of RAM.
- dma_wdata  in  16  DMA write data.
- dma_wvalid  in  1  DMA write data is valid.
- dma_wready  out  1  DMA write word accepted this cycle.
- dma_rdata  out  16  DMA read data.
- dma_rvalid  out  1  DMA read data is valid.
- dma_rready  in  1  downstream accepts dma_rdata.
- dma_busy  out  1  a transfer is in progress.
- dma_done  out  1  one-cycle pulse at the end of a transfer.
- ram_address  out  16  RAM address; bits [15:12] are always 0.
- ram_in  out  16  RAM write data.
- ram_load  out  1  RAM write enable.
- ram_out  in  16  combinational RAM read data.

Function
REQ-003 The DMA state machine SHALL have three states, IDLE, RUN and FLUSH, and SHALL register cmd_write, ptr[11:0] and remaining[11:0] when it accepts a command.
REQ-004 In IDLE, dma_start SHALL load ptr=dma_base, remaining=dma_len and cmd_write=dma_write, and go to RUN; if dma_len=0, the block SHALL instead stay in IDLE and pulse dma_done on the next cycle without any RAM access.
REQ-005 dma_start SHALL be ignored in RUN and FLUSH.
REQ-006 dma_want SHALL be RUN && (cmd_write ? dma_wvalid : (!dma_rvalid || dma_rready)).
REQ-007 The grant SHALL go to the DMA when dma_want && (!cpu_req || starve_cnt==STARVE_MAX), and to the CPU otherwise whenever cpu_req is high.
REQ-008 cpu_wait SHALL be cpu_req && DMA grant, combinational in the same cycle.
REQ-009 starve_cnt SHALL increment when dma_want is high and the CPU is granted, and SHALL clear on a DMA grant or when dma_want is low.
REQ-010 The RAM port SHALL be driven combinationally from the grant:
- CPU grant: ram_address={4'b0, cpu_address[11:0]}, ram_in=cpu_in, ram_load=cpu_load.
- DMA grant: ram_address={4'b0, ptr}, ram_in=dma_wdata, ram_load=cmd_write.
- No grant: ram_load=0.
REQ-011 dma_wready SHALL equal DMA grant && cmd_write; a word transfers when dma_wvalid && dma_wready.
REQ-012 On a DMA read grant, dma_rdata SHALL register ram_out and dma_rvalid SHALL be set at the next edge; dma_rvalid SHALL clear when dma_rready is high and no new word is loaded in the same cycle.
REQ-013 Every DMA grant SHALL advance ptr (3839 wraps to 0, RAM is 3840 words) and decrement remaining.
REQ-014 When the grant consumes the last word, a write transfer SHALL go to IDLE with dma_done pulsing the next cycle; a read transfer SHALL go to FLUSH.
REQ-015 FLUSH SHALL wait until dma_rvalid && dma_rready, then go to IDLE and pulse dma_done on the next cycle.
REQ-016 dma_busy SHALL be high in RUN and FLUSH.
REQ-017 The CPU read latency SHALL be 0 cycles: cpu_out is valid in the granted cycle.

Reset
REQ-018 While reset is high, the block SHALL be in IDLE with starve_cnt, ptr and remaining at 0 and dma_busy, dma_done, dma_rvalid and dma_rdata at 0; the combinational outputs then follow from these values.
REQ-019 Reset during RUN or FLUSH SHALL abort the transfer with no dma_done pulse; any partially written RAM contents are left as they are.

Structure
REQ-020 A shared package ram_pkg SHALL hold RAM_WORDS=3840, ADDR_W=12, DATA_W=16 and the state enum {IDLE, RUN, FLUSH}.
REQ-021 ram_arbiter SHALL have no sub-modules; the existing RAM block is instantiated beside it at top level.

Verification
REQ-022 Scenario: cpu_req idle, write command base=10, len=3, wvalid held high -> RAM[10..12] written over 3 consecutive cycles, then dma_done pulses 1 cycle after the last word.
REQ-023 Scenario: cpu_req held high throughout a write, STARVE_MAX=4 -> the pattern is 4 CPU grants then 1 DMA grant with cpu_wait=1 in that DMA-grant cycle, repeating.
REQ-024 Scenario: read command base=3838, len=4, rready toggling 1,0,1,0... -> words from addresses 3838, 3839, 0 and 1 delivered in order with none lost or duplicated, then dma_done pulses.
REQ-025 Scenario: dma_start with len=0 -> no ram_load, dma_busy stays 0, dma_done pulses 1 cycle after the start.
REQ-026 Scenario: reset asserted mid-read with dma_rvalid=1 -> the next cycle shows dma_rvalid=0, dma_busy=0 and no dma_done pulse.
REQ-027 Scenario: dma_start pulsed while busy -> the command is ignored and the original transfer completes unchanged.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared RAM geometry, DMA state encoding and address-wrap helper.
package ram_pkg;

  localparam int RAM_WORDS = 3840;
  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } dma_state_e;

  // Next word address; the RAM is not a power of two deep, so the last word wraps to 0.
  function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(RAM_WORDS - 1)) ? '0 : p + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter between a CPU (priority, zero-latency reads) and a
// streaming DMA engine. The DMA is guaranteed a slot after STARVE_MAX
// consecutive denied cycles.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_req,
  input  logic [15:0]        cpu_address,
  input  logic [DATA_W-1:0]  cpu_in,
  input  logic               cpu_load,
  output logic [DATA_W-1:0]  cpu_out,
  output logic               cpu_wait,
  input  logic               dma_start,
  input  logic [ADDR_W-1:0]  dma_base,
  input  logic [ADDR_W-1:0]  dma_len,
  input  logic               dma_write,
  input  logic [DATA_W-1:0]  dma_wdata,
  input  logic               dma_wvalid,
  output logic               dma_wready,
  output logic [DATA_W-1:0]  dma_rdata,
  output logic               dma_rvalid,
  input  logic               dma_rready,
  output logic               dma_busy,
  output logic               dma_done,
  output logic [15:0]        ram_address,
  output logic [DATA_W-1:0]  ram_in,
  output logic               ram_load,
  input  logic [DATA_W-1:0]  ram_out
);

  // Counter wide enough to hold STARVE_MAX (at least one bit even for 0).
  localparam int             SW         = $clog2(STARVE_MAX + 2);
  localparam logic [SW-1:0]  STARVE_LIM = SW'(STARVE_MAX);
  localparam int             PAD_W      = 16 - ADDR_W;

  dma_state_e          state_q, state_d;
  logic                cmd_write_q, cmd_write_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   remaining_q, remaining_d;
  logic [SW-1:0]       starve_cnt_q, starve_cnt_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                done_q, done_d;

  logic dma_want;
  logic dma_grant;
  logic cpu_grant;
  logic cpu_addr_unused;

  // The CPU address space is wider than the RAM; upper bits are ignored.
  assign cpu_addr_unused = ^cpu_address[15:ADDR_W];

  // Arbitration and RAM port steering, all combinational in the access cycle.
  always_comb begin
    dma_want    = 1'b0;
    dma_grant   = 1'b0;
    cpu_grant   = 1'b0;
    ram_address = '0;
    ram_in      = '0;
    ram_load    = 1'b0;

    if (state_q == RUN) begin
      dma_want = cmd_write_q ? dma_wvalid : (!rvalid_q || dma_rready);
    end
    dma_grant = dma_want && (!cpu_req || (starve_cnt_q == STARVE_LIM));
    cpu_grant = cpu_req && !dma_grant;

    if (dma_grant) begin
      ram_address = {{PAD_W{1'b0}}, ptr_q};
      ram_in      = dma_wdata;
      ram_load    = cmd_write_q;
    end else if (cpu_grant) begin
      ram_address = {{PAD_W{1'b0}}, cpu_address[ADDR_W-1:0]};
      ram_in      = cpu_in;
      ram_load    = cpu_load;
    end
  end

  assign cpu_wait   = cpu_req && dma_grant;
  assign cpu_out    = ram_out;
  assign dma_wready = dma_grant && cmd_write_q;
  assign dma_rdata  = rdata_q;
  assign dma_rvalid = rvalid_q;
  assign dma_done   = done_q;
  assign dma_busy   = (state_q != IDLE);

  // DMA command FSM, starvation counter and read-data holding register.
  always_comb begin
    state_d      = state_q;
    cmd_write_d  = cmd_write_q;
    ptr_d        = ptr_q;
    remaining_d  = remaining_q;
    starve_cnt_d = starve_cnt_q;
    rvalid_d     = rvalid_q;
    rdata_d      = rdata_q;
    done_d       = 1'b0;

    if (dma_grant || !dma_want) begin
      starve_cnt_d = '0;
    end else if (cpu_grant) begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end

    // A new word overwrites the holding register; rready only drains it when
    // nothing replaces it in the same cycle.
    if (dma_grant && !cmd_write_q) begin
      rvalid_d = 1'b1;
      rdata_d  = ram_out;
    end else if (dma_rready) begin
      rvalid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (dma_start) begin
          if (dma_len == '0) begin
            done_d = 1'b1;
          end else begin
            ptr_d       = dma_base;
            remaining_d = dma_len;
            cmd_write_d = dma_write;
            state_d     = RUN;
          end
        end
      end
      RUN: begin
        if (dma_grant) begin
          ptr_d       = ptr_next(ptr_q);
          remaining_d = remaining_q - ADDR_W'(1);
          if (remaining_q == ADDR_W'(1)) begin
            // Reads still have the last word in the holding register.
            state_d = cmd_write_q ? IDLE : FLUSH;
            done_d  = cmd_write_q;
          end
        end
      end
      FLUSH: begin
        if (rvalid_q && dma_rready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset; reset aborts any transfer silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cmd_write_q  <= 1'b0;
      ptr_q        <= '0;
      remaining_q  <= '0;
      starve_cnt_q <= '0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_write_q  <= cmd_write_d;
      ptr_q        <= ptr_d;
      remaining_q  <= remaining_d;
      starve_cnt_q <= starve_cnt_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural 3840-word RAM beside it.
module tb_ram_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic [15:0] cpu_address;
  logic [15:0] cpu_in;
  logic        cpu_load;
  logic [15:0] cpu_out;
  logic        cpu_wait;
  logic        dma_start;
  logic [11:0] dma_base;
  logic [11:0] dma_len;
  logic        dma_write;
  logic [15:0] dma_wdata;
  logic        dma_wvalid;
  logic        dma_wready;
  logic [15:0] dma_rdata;
  logic        dma_rvalid;
  logic        dma_rready;
  logic        dma_busy;
  logic        dma_done;
  logic [15:0] ram_address;
  logic [15:0] ram_in;
  logic        ram_load;
  logic [15:0] ram_out;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_wr_q[$];
  logic [15:0] exp_rd_q[$];
  int          exp_done_q[$];

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:3839];

  ram_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_address(cpu_address), .cpu_in(cpu_in),
    .cpu_load(cpu_load), .cpu_out(cpu_out), .cpu_wait(cpu_wait),
    .dma_start(dma_start), .dma_base(dma_base), .dma_len(dma_len),
    .dma_write(dma_write), .dma_wdata(dma_wdata), .dma_wvalid(dma_wvalid),
    .dma_wready(dma_wready), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .dma_rready(dma_rready), .dma_busy(dma_busy), .dma_done(dma_done),
    .ram_address(ram_address), .ram_in(ram_in), .ram_load(ram_load),
    .ram_out(ram_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: combinational read, registered write.
  assign ram_out = mem[ram_address[11:0]];
  always @(posedge clk) begin
    if (ram_load && ram_address < 16'd3840) mem[ram_address[11:0]] <= ram_in;
  end
  initial begin
    for (int i = 0; i < 3840; i++) mem[i] <= 16'hA000 ^ 16'(i);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every RAM write, DMA read handshake and done pulse must be expected.
  always @(negedge clk) begin
    if (!reset) begin
      if (ram_load) begin
        if (exp_wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr %0h data %0h", ram_address, ram_in);
        end else begin
          wr_t e;
          e = exp_wr_q.pop_front();
          check("wr_addr", 32'(ram_address), 32'(e.addr));
          check("wr_data", 32'(ram_in), 32'(e.data));
        end
      end
      if (dma_rvalid && dma_rready) begin
        if (exp_rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: data %0h", dma_rdata);
        end else begin
          logic [15:0] d;
          d = exp_rd_q.pop_front();
          check("rd_data", 32'(dma_rdata), 32'(d));
        end
      end
      if (dma_done) begin
        checks++;
        if (exp_done_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got 1 expected 0");
        end else begin
          void'(exp_done_q.pop_front());
        end
      end
    end
  end

  task automatic run_write(input logic [11:0] base, input logic [11:0] len,
                           input logic [15:0] tag, input bit hold_cpu, input int poke);
    int   k;
    int   cyc;
    logic acc;
    bit   exp_acc;
    logic [11:0] a;
    wr_t  e;
    a = base;
    for (int i = 0; i < int'(len); i++) begin
      e.addr = {4'b0, a};
      e.data = tag + 16'(i);
      exp_wr_q.push_back(e);
      a = (a == 12'd3839) ? 12'd0 : a + 12'd1;
    end
    exp_done_q.push_back(1);
    cpu_req = hold_cpu; cpu_load = 1'b0; cpu_address = 16'd0;
    dma_base = base; dma_len = len; dma_write = 1'b1; dma_start = 1'b1;
    dma_wvalid = 1'b1; dma_wdata = tag;
    @(posedge clk); #1;
    dma_start = 1'b0;
    k = 0; cyc = 0;
    while (k < int'(len) && cyc < 200) begin
      if (cyc == poke) begin
        dma_start = 1'b1; dma_base = 12'd300; dma_len = 12'd1; dma_write = 1'b0;
      end else begin
        dma_start = 1'b0;
      end
      exp_acc = hold_cpu ? (cyc % 5 == 4) : 1'b1;
      @(negedge clk);
      acc = dma_wready;
      check("wready", 32'(acc), 32'(exp_acc));
      check("cpu_wait", 32'(cpu_wait), 32'(hold_cpu && exp_acc));
      check("busy_run", 32'(dma_busy), 32'd1);
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        k++;
        dma_wdata = tag + 16'(k);
      end
    end
    dma_start = 1'b0; dma_wvalid = 1'b0; cpu_req = 1'b0;
    check("wr_cycles", 32'(cyc), hold_cpu ? 32'(5 * int'(len)) : 32'(len));
    @(negedge clk);
    check("wr_done", 32'(dma_done), 32'd1);
    check("wr_busy_end", 32'(dma_busy), 32'd0);
    @(negedge clk);
    check("wr_done_clear", 32'(dma_done), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic cpu_read(input logic [15:0] addr, input logic [15:0] exp, input string name);
    cpu_req = 1'b1; cpu_load = 1'b0; cpu_address = addr;
    @(negedge clk);
    check(name, 32'(cpu_out), 32'(exp));
    check("cpu_no_wait", 32'(cpu_wait), 32'd0);
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  initial begin
    wr_t e;
    int  cyc;
    logic seen;
    reset = 1'b1; cpu_req = 1'b0; cpu_address = '0; cpu_in = '0; cpu_load = 1'b0;
    dma_start = 1'b0; dma_base = '0; dma_len = '0; dma_write = 1'b0;
    dma_wdata = '0; dma_wvalid = 1'b0; dma_rready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(dma_busy), 32'd0);
    check("rst_done", 32'(dma_done), 32'd0);
    check("rst_rvalid", 32'(dma_rvalid), 32'd0);
    check("rst_rdata", 32'(dma_rdata), 32'd0);
    check("rst_ram_load", 32'(ram_load), 32'd0);
    check("rst_cpu_wait", 32'(cpu_wait), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // CPU zero-latency read with ignored upper address bits, then a write
    cpu_req = 1'b1; cpu_address = 16'hF005;
    @(negedge clk);
    check("cpu_rd_addr", 32'(ram_address), 32'h0005);
    check("cpu_rd_data", 32'(cpu_out), 32'hA005);
    @(posedge clk); #1;
    cpu_load = 1'b1; cpu_address = 16'd20; cpu_in = 16'h1234;
    e.addr = 16'd20; e.data = 16'h1234;
    exp_wr_q.push_back(e);
    @(posedge clk); #1;
    cpu_load = 1'b0; cpu_req = 1'b0;
    cpu_read(16'd20, 16'h1234, "cpu_readback");

    // DMA write, CPU idle
    run_write(12'd10, 12'd3, 16'hC000, 1'b0, -1);
    // DMA write under continuous CPU traffic: 4 CPU grants then 1 DMA grant
    run_write(12'd100, 12'd3, 16'hD000, 1'b1, -1);

    // DMA read across the wrap with rready toggling
    exp_rd_q.push_back(16'hAEFE);
    exp_rd_q.push_back(16'hAEFF);
    exp_rd_q.push_back(16'hA000);
    exp_rd_q.push_back(16'hA001);
    exp_done_q.push_back(1);
    dma_base = 12'd3838; dma_len = 12'd4; dma_write = 1'b0; dma_rready = 1'b1;
    dma_start = 1'b1;
    @(posedge clk); #1;
    dma_start = 1'b0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 100) begin
      dma_rready = ~dma_rready;
      @(negedge clk);
      seen = dma_done;
      @(posedge clk); #1;
      cyc++;
    end
    dma_rready = 1'b0;
    check("rd_done_seen", 32'(seen), 32'd1);
    check("rd_all_delivered", 32'(exp_rd_q.size()), 32'd0);
    check("rd_done_cycle", 32'(cyc), 32'd9);

    // Zero-length command
    exp_done_q.push_back(1);
    dma_base = 12'd7; dma_len = 12'd0; dma_write = 1'b1; dma_start = 1'b1;
    @(negedge clk);
    check("len0_busy0", 32'(dma_busy), 32'd0);
    @(posedge clk); #1;
    dma_start = 1'b0;
    @(negedge clk);
    check("len0_done", 32'(dma_done), 32'd1);
    check("len0_busy1", 32'(dma_busy), 32'd0);
    @(negedge clk);
    check("len0_done_clear", 32'(dma_done), 32'd0);
    @(posedge clk); #1;

    // Start pulse while busy is ignored
    run_write(12'd200, 12'd4, 16'hE000, 1'b0, 1);

    // Reset in the middle of a stalled read
    dma_base = 12'd50; dma_len = 12'd5; dma_write = 1'b0; dma_rready = 1'b0;
    dma_start = 1'b1;
    @(posedge clk); #1;
    dma_start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_rvalid_pre", 32'(dma_rvalid), 32'd1);
    check("abort_rdata_pre", 32'(dma_rdata), 32'hA032);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_rvalid", 32'(dma_rvalid), 32'd0);
    check("abort_busy", 32'(dma_busy), 32'd0);
    check("abort_done", 32'(dma_done), 32'd0);
    check("abort_rdata", 32'(dma_rdata), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // RAM contents after the transfers
    cpu_read(16'd11, 16'hC001, "mem_11");
    cpu_read(16'd102, 16'hD002, "mem_102");
    cpu_read(16'd202, 16'hE002, "mem_202");
    cpu_read(16'd300, 16'hA12C, "mem_300_untouched");

    repeat (2) @(posedge clk);
    check("wr_queue_empty", 32'(exp_wr_q.size()), 32'd0);
    check("rd_queue_empty", 32'(exp_rd_q.size()), 32'd0);
    check("done_queue_empty", 32'(exp_done_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
